wdt_counter: RTL
================

WDT_COUNTER -- requirements
Module: wdt_counter

Interface
REQ-001 Parameter PRESC_W, default 8: prescaler divider width.
REQ-002 clk_i  input  1  sole clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 en_i  input  1  level; 1 = count, 0 = stop and hold counter value.
REQ-005 presc_i  input  PRESC_W  divider; counter advances once every presc_i+1 enabled cycles.
REQ-006 load_i  input  1  single-cycle strobe; loads load_val_i into counter.
REQ-007 load_val_i  input  32  counter load value.
REQ-008 oneshot_i  input  1  1 = stop in HALT after first wrap; 0 = free-running.
REQ-009 pres_counter_o  output  32  current counter value, registered.
REQ-010 tick_o  output  1  one-cycle pulse, registered; counter advanced this cycle.
REQ-011 ovf_o  output  1  one-cycle pulse, registered; counter wrapped 32'hFFFF_FFFF -> 0.
REQ-012 running_o  output  1  1 while FSM is in RUN.

Function
REQ-013 FSM states: IDLE, RUN, HALT.
REQ-014 IDLE -> RUN when en_i=1; RUN -> IDLE when en_i=0; HALT -> IDLE when en_i=0; HALT -> RUN on load_i=1 with en_i=1.
REQ-015 Prescaler count increments each cycle in RUN. When count >= presc_i: count clears to 0 and a tick occurs; this also covers presc_i lowered mid-count.
REQ-016 presc_i=0: tick every RUN cycle.
REQ-017 Tick: counter increments by 1 modulo 2^32; tick_o=1 in the cycle the new value appears on pres_counter_o.
REQ-018 Tick when counter = 32'hFFFF_FFFF: counter becomes 0; ovf_o=1 and tick_o=1 in the same cycle.
REQ-019 RUN with oneshot_i=1: wrap sends FSM to HALT. In HALT, counter held at 0 and prescaler held at 0.
REQ-020 load_i=1 in any state: counter <= load_val_i next cycle; prescaler count cleared; no tick_o or ovf_o that cycle, even if a tick or wrap would coincide (load wins).
REQ-021 en_i=0: counter holds its value; prescaler count clears to 0; tick_o=0, ovf_o=0.
REQ-022 After re-enable, first tick occurs presc_i+1 cycles after RUN entry.
REQ-023 Changing oneshot_i in RUN takes effect at the next wrap only.
REQ-024 ovf_o and tick_o are never asserted for two consecutive cycles unless presc_i=0 and counter wraps repeatedly; ovf_o never repeats within fewer than 2^32 ticks absent load.

Reset
REQ-025 Asynchronous reset (rst_ni=0) forces: state IDLE, pres_counter_o=0, prescaler count 0, tick_o=0, ovf_o=0, running_o=0.
REQ-026 Reset mid-RUN aborts immediately. After release, the block waits in IDLE until en_i=1.
REQ-027 No output glitches to non-reset values while rst_ni=0, regardless of load_i.

Structure
REQ-028 Shared package wdt_pkg holds: FSM state enum wdt_state_e, constant WDT_CNT_W=32, constant WDT_CNT_MAX=32'hFFFF_FFFF.
REQ-029 Sub-module wdt_prescaler (clk_i, rst_ni, en_i, clr_i, presc_i, tick_o) encapsulates the divider; the top level holds the FSM and counter.
REQ-030 All outputs are driven directly from flops; no combinational input-to-output path.

Verification
REQ-031 presc_i=3, en_i=1 from reset -> tick_o every 4th cycle; pres_counter_o = 1, 2, 3 at ticks 1..3.
REQ-032 load 32'hFFFF_FFFE, presc_i=0, oneshot_i=0, en_i=1 -> pres_counter_o = FFFF_FFFF, then 0 with ovf_o=1 for one cycle, then 1.
REQ-033 Same as REQ-032 with oneshot_i=1 -> after wrap, running_o=0, counter stays 0 for 20 cycles, no further tick_o; then load 5 with en_i=1 -> RUN, counter 5, then 6.
REQ-034 load_i asserted in the cycle a wrap tick is due (counter FFFF_FFFF, presc_i=0) with load_val_i=0x10 -> counter 0x10, ovf_o=0, tick_o=0.
REQ-035 presc_i=10, prescaler count at 7, presc_i changed to 2 -> tick next cycle, then every 3rd cycle.
REQ-036 Assert rst_ni=0 mid-count at counter 0x1234 -> all outputs 0 immediately; after release with en_i=1, first tick after presc_i+1 cycles, counter=1.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog counter block.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } wdt_state_e;

    localparam int unsigned           WDT_CNT_W   = 32;
    localparam logic [WDT_CNT_W-1:0] WDT_CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic is_wrap(input logic [WDT_CNT_W-1:0] cnt);
        return cnt == WDT_CNT_MAX;
    endfunction

endpackage

// File: rtl/wdt_counter_if.sv
// Control and status bundle between a host and the watchdog counter.
interface wdt_counter_if #(
    parameter int unsigned PRESC_W = 8
);
    import wdt_pkg::*;

    logic                 en_i;
    logic [PRESC_W-1:0]   presc_i;
    logic                 load_i;
    logic [WDT_CNT_W-1:0] load_val_i;
    logic                 oneshot_i;
    logic [WDT_CNT_W-1:0] pres_counter_o;
    logic                 tick_o;
    logic                 ovf_o;
    logic                 running_o;

    modport master (
        output en_i, presc_i, load_i, load_val_i, oneshot_i,
        input  pres_counter_o, tick_o, ovf_o, running_o
    );

    modport slave (
        input  en_i, presc_i, load_i, load_val_i, oneshot_i,
        output pres_counter_o, tick_o, ovf_o, running_o
    );

endinterface

// File: rtl/wdt_prescaler.sv
// Clock divider: tick is due once the count has reached the divider value.
module wdt_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic               due;

    // Compare with >= so lowering presc_i below the running count ticks at once.
    always_comb begin
        due    = (cnt_q >= presc_i);
        tick_o = en_i & ~clr_i & due;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = due ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wdt_counter.sv
// Watchdog/interval counter: IDLE/RUN/HALT FSM, prescaled 32-bit counter.
//   state   | meaning
//   IDLE    | disabled, counter holds
//   RUN     | counting prescaled ticks
//   HALT    | one-shot wrapped, counter parked at 0 until reload
module wdt_counter
    import wdt_pkg::*;
#(
    parameter int unsigned PRESC_W = 8
) (
    input logic         clk_i,
    input logic         rst_ni,
    wdt_counter_if.slave bus
);

    wdt_state_e           state_q, state_d;
    logic [WDT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 ovf_q, ovf_d;
    logic                 running_q, running_d;

    logic presc_en;
    logic presc_clr;
    logic presc_tick;
    logic wrap;

    assign presc_en  = (state_q == ST_RUN) && bus.en_i;
    assign presc_clr = bus.load_i || !presc_en;

    wdt_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (presc_en),
        .clr_i   (presc_clr),
        .presc_i (bus.presc_i),
        .tick_o  (presc_tick)
    );

    // presc_tick is already suppressed by load, so a load always beats a wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        ovf_d   = 1'b0;
        wrap    = presc_tick && is_wrap(cnt_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.en_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.en_i)                   state_d = ST_IDLE;
                else if (wrap && bus.oneshot_i)  state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!bus.en_i)       state_d = ST_IDLE;
                else if (bus.load_i) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.load_i) begin
            cnt_d = bus.load_val_i;
        end else if (presc_tick) begin
            cnt_d  = cnt_q + 1'b1;
            tick_d = 1'b1;
            ovf_d  = wrap;
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
        end
    end

    assign bus.pres_counter_o = cnt_q;
    assign bus.tick_o         = tick_q;
    assign bus.ovf_o          = ovf_q;
    assign bus.running_o      = running_q;

endmodule
